cmd_line_tx: RTL and testbench
==============================

CMD_LINE_TX -- requirements
Module: cmd_line_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, meaning clk cycles per UART bit (25 MHz / 115200).
REQ-002 SHALL have port clk  input  1  system clock; all logic is clocked on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  command present on cmd_id/x/y.
REQ-005 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-006 SHALL have port cmd_id  input  4  command code.
REQ-007 SHALL have port x  input  7  x coordinate, 0..127.
REQ-008 SHALL have port y  input  7  y coordinate, 0..127.
REQ-009 SHALL have port tx  output  1  UART serial line to the Bluetooth module; idles high.
REQ-010 SHALL have port busy  output  1  a line is being transmitted.

Function
REQ-011 SHALL accept a command on the cycle cmd_valid=1 and cmd_ready=1, registering cmd_id, x and y on that edge.
REQ-012 SHALL drive cmd_ready=0 and busy=1 from the cycle after acceptance until the last stop bit of the line completes.
REQ-013 SHALL ignore cmd_valid while cmd_ready=0; there is no queue and the ignored command is lost.
REQ-014 SHALL format each accepted command as a 10-byte ASCII line: hex digit of cmd_id ('0'-'9','A'-'F'), ' ', three decimal digits of x, ' ', three decimal digits of y, 0x0A.
REQ-015 SHALL zero-pad decimal fields, e.g. x=5 -> "005" and x=127 -> "127".
REQ-016 SHALL send each byte as 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), with each bit held exactly CLKS_PER_BIT cycles.
REQ-017 SHALL send the bytes back to back with no idle gap, so one line lasts exactly 100*CLKS_PER_BIT cycles.
REQ-018 SHALL drive the start bit of byte 0 beginning on the cycle after acceptance.
REQ-019 SHALL use top-level states IDLE (cmd_ready=1), SEND (byte index 0..9 handed to serializer), and WAIT (serializer finishing the current byte).
REQ-020 SHALL transition IDLE->SEND on acceptance, SEND->WAIT on each byte, and WAIT->SEND on byte done while index<9.
REQ-021 SHALL transition WAIT->IDLE on byte done while index=9.
REQ-022 SHALL raise cmd_ready in the cycle after the final stop bit ends, so a command held on cmd_valid is accepted then (back-to-back lines).
REQ-023 SHALL hold tx=1 whenever no frame is in progress.

Reset
REQ-024 SHALL on rst, regardless of clk, force tx=1, cmd_ready=0, busy=0, state IDLE, and byte index, bit counters and baud counter to 0.
REQ-025 SHALL drive cmd_ready=1 from the first clk edge after rst deasserts.
REQ-026 SHALL abort an in-flight frame on reset mid-line, returning tx high immediately, and SHALL NOT resume the aborted line.

Structure
REQ-027 SHALL keep in a shared package the line length (10), the ASCII constants (space 0x20, LF 0x0A, '0' 0x30, 'A' 0x41) and the top-level state encoding.
REQ-028 SHALL instantiate one sub-module, uart_tx (byte in, start strobe, tx, done pulse, CLKS_PER_BIT parameter), which is the natural counterpart of the existing uart_rx.
REQ-029 SHALL compute the decimal digits combinationally from the registered x/y: hundreds 0/1, then tens and units of the remainder.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-030 SHALL cover: cmd_id=5, x=12, y=99 -> tx decodes "5 012 099\n" (35 20 30 31 32 20 30 39 39 0A) and busy is high for 400 cycles.
REQ-031 SHALL cover: cmd_id=0xF, x=127, y=0 -> "F 127 000\n" and the LSB-first bit order is checked on byte 0 (0x46).
REQ-032 SHALL cover: cmd_valid pulsed with new values at mid-line -> the second command is ignored, the line is unchanged and cmd_ready stays 0.
REQ-033 SHALL cover: cmd_valid held high across two commands -> the second line's start bit begins with no gap beyond the one acceptance cycle after the first stop bit.
REQ-034 SHALL cover: rst asserted during the data bits of byte 4 -> tx=1 in the same cycle, then cmd_ready=1 one edge after deassert, and a fresh command is sent in full.
REQ-035 SHALL cover: CLKS_PER_BIT=217 -> bit width measured as 217 cycles and the line as 21700 cycles.

Source files
------------

// File: rtl/cmd_line_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmd_line_tx_pkg
// Purpose  : Shared constants, state encoding and formatting helpers for the
//            command-line UART transmitter.
// Contents : line length, ASCII constants, top-level state enum, hex/decimal
//            digit helpers.
// Revision : 1.0 - initial release
// ============================================================================
package cmd_line_tx_pkg;

    // Bytes per transmitted line: "H XXX YYY\n"
    localparam int C_LINE_LEN = 10;

    localparam logic [7:0] C_ASCII_SPACE = 8'h20;
    localparam logic [7:0] C_ASCII_LF    = 8'h0A;
    localparam logic [7:0] C_ASCII_ZERO  = 8'h30;
    localparam logic [7:0] C_ASCII_A     = 8'h41;

    // Top-level line sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // ready for a command
        ST_SEND = 2'd1,   // byte at the current index has just been handed over
        ST_WAIT = 2'd2    // serializer finishing the current byte
    } line_state_t;

    // Decimal digits of a 0..127 value
    typedef struct packed {
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] units;
    } dec3_t;

    // Upper-case hexadecimal ASCII digit of a nibble
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] r_unused_free;
        r_unused_free = (nib < 4'd10) ? (C_ASCII_ZERO + {4'd0, nib})
                                      : (C_ASCII_A + {4'd0, nib - 4'd10});
        return r_unused_free;
    endfunction

    // ASCII character of a decimal digit 0..9
    function automatic logic [7:0] dec_ascii(input logic [3:0] dig);
        return C_ASCII_ZERO + {4'd0, dig};
    endfunction

    // Split a 7-bit value into hundreds (only 0 or 1 is possible), tens, units
    function automatic dec3_t to_dec3(input logic [6:0] val);
        logic [6:0] rem;
        dec3_t      d;
        d.hundreds = (val >= 7'd100) ? 4'd1 : 4'd0;
        rem        = (val >= 7'd100) ? (val - 7'd100) : val;
        d.tens     = 4'(rem / 7'd10);
        d.units    = 4'(rem % 7'd10);
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_line_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : cmd_line_tx_if
// Purpose  : Command handshake bundle between a command producer and the
//            line transmitter.
// Signals  : cmd_valid (producer -> tx)  command present
//            cmd_ready (tx -> producer)  transmitter can accept
//            cmd_id[3:0], x[6:0], y[6:0] command payload
// Revision : 1.0 - initial release
// ============================================================================
interface cmd_line_tx_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_id;
    logic [6:0] x;
    logic [6:0] y;

    modport master (
        output cmd_valid,
        output cmd_id,
        output x,
        output y,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_id,
        input  x,
        input  y,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/cmd_line_tx_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : 8N1 UART byte serializer. A start strobe loads a byte and the
//            frame begins on the very next cycle. A strobe during the final
//            stop-bit cycle chains a new frame with no idle gap.
// Ports    : clk, rst       clock, asynchronous active-high reset
//            i_start        load i_data and begin a frame
//            i_data[7:0]    byte to send
//            o_tx           serial line, idles high
//            o_done         high during the last cycle of the stop bit
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_start,
    input  wire logic [7:0] i_data,
    output logic            o_tx,
    output logic            o_done
);

    localparam int                  C_BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [C_BAUD_W-1:0] C_BAUD_LAST = C_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]          C_STOP_BIT  = 4'd9;

    logic                r_active;
    logic [C_BAUD_W-1:0] r_baud;
    logic [3:0]          r_bit;     // 0 = start, 1..8 = data, 9 = stop
    logic [8:0]          r_shift;   // remaining data bits with stop bit on top
    logic                r_tx;

    logic w_bit_end;
    assign w_bit_end = (r_baud == C_BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_baud   <= '0;
            r_bit    <= 4'd0;
            r_shift  <= 9'h1FF;
            r_tx     <= 1'b1;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_baud   <= '0;
            r_bit    <= 4'd0;
            r_shift  <= {1'b1, i_data};
            r_tx     <= 1'b0;
        end else if (r_active) begin
            if (w_bit_end) begin
                r_baud <= '0;
                if (r_bit == C_STOP_BIT) begin
                    r_active <= 1'b0;
                    r_bit    <= 4'd0;
                    r_tx     <= 1'b1;
                end else begin
                    // The 1 shifted in at the top becomes the stop bit
                    r_bit   <= r_bit + 4'd1;
                    r_tx    <= r_shift[0];
                    r_shift <= {1'b1, r_shift[8:1]};
                end
            end else begin
                r_baud <= r_baud + 1'b1;
            end
        end
    end

    assign o_tx   = r_tx;
    assign o_done = r_active & (r_bit == C_STOP_BIT) & w_bit_end;

endmodule
`default_nettype wire

// File: rtl/cmd_line_tx.sv
`default_nettype none
// ============================================================================
// Module   : cmd_line_tx
// Purpose  : Formats an accepted command as the ASCII line "H XXX YYY\n" and
//            sends it over UART (8N1), bytes back to back.
// Ports    : clk, rst       clock, asynchronous active-high reset
//            cmd (slave)    cmd_valid/cmd_ready handshake, cmd_id, x, y
//            tx             UART line, idles high
//            busy           a line is being transmitted
// Params   : CLKS_PER_BIT   clk cycles per UART bit
// Revision : 1.0 - initial release
// ============================================================================
module cmd_line_tx
    import cmd_line_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  wire logic     clk,
    input  wire logic     rst,
    cmd_line_tx_if.slave  cmd,
    output logic          tx,
    output logic          busy
);

    localparam logic [3:0] C_LAST_IDX = 4'(C_LINE_LEN - 1);

    line_state_t r_state;
    logic [3:0]  r_idx;
    logic [3:0]  r_id;
    logic [6:0]  r_x;
    logic [6:0]  r_y;
    logic        r_ready;
    logic        r_busy;

    logic        w_accept;
    logic        w_done;
    logic        w_last;
    logic        w_start;
    logic [3:0]  w_next_idx;
    logic [7:0]  w_line_byte;
    logic [7:0]  w_tx_byte;
    dec3_t       w_xd;
    dec3_t       w_yd;

    assign w_accept   = cmd.cmd_valid & r_ready;
    assign w_last     = (r_idx == C_LAST_IDX);
    assign w_next_idx = r_idx + 4'd1;
    assign w_xd       = to_dec3(r_x);
    assign w_yd       = to_dec3(r_y);

    // Byte that follows the one currently on the line
    always_comb begin
        w_line_byte = C_ASCII_LF;
        case (w_next_idx)
            4'd0:    w_line_byte = hex_ascii(r_id);
            4'd1:    w_line_byte = C_ASCII_SPACE;
            4'd2:    w_line_byte = dec_ascii(w_xd.hundreds);
            4'd3:    w_line_byte = dec_ascii(w_xd.tens);
            4'd4:    w_line_byte = dec_ascii(w_xd.units);
            4'd5:    w_line_byte = C_ASCII_SPACE;
            4'd6:    w_line_byte = dec_ascii(w_yd.hundreds);
            4'd7:    w_line_byte = dec_ascii(w_yd.tens);
            4'd8:    w_line_byte = dec_ascii(w_yd.units);
            default: w_line_byte = C_ASCII_LF;
        endcase
    end

    // Byte 0 is launched on the acceptance edge itself, before the command
    // registers are loaded, so it is taken straight from the input. Later
    // bytes are launched in the serializer's final stop-bit cycle so the
    // frames abut.
    assign w_start   = ((r_state == ST_IDLE) & w_accept) |
                       ((r_state == ST_WAIT) & w_done & ~w_last);
    assign w_tx_byte = (r_state == ST_IDLE) ? hex_ascii(cmd.cmd_id) : w_line_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= 4'd0;
            r_id    <= 4'd0;
            r_x     <= 7'd0;
            r_y     <= 7'd0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_id    <= cmd.cmd_id;
                        r_x     <= cmd.x;
                        r_y     <= cmd.y;
                        r_idx   <= 4'd0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_done) begin
                        if (w_last) begin
                            r_idx   <= 4'd0;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx   <= w_next_idx;
                            r_state <= ST_SEND;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd.cmd_ready = r_ready;
    assign busy          = r_busy;

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_data  (w_tx_byte),
        .o_tx    (tx),
        .o_done  (w_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_cmd_line_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_line_tx
// Purpose  : Self-checking bench for cmd_line_tx. Directed and random
//            commands; the expected ASCII line and bit waveform come from a
//            simple model of the line format.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_line_tx;

    localparam int CPB   = 4;
    localparam int CPB_B = 217;
    localparam int LINE  = 100 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cmd_line_tx_if ifa ();
    cmd_line_tx_if ifb ();
    logic tx_a, busy_a, tx_b, busy_b;

    cmd_line_tx #(.CLKS_PER_BIT(CPB)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .cmd  (ifa),
        .tx   (tx_a),
        .busy (busy_a)
    );

    cmd_line_tx #(.CLKS_PER_BIT(CPB_B)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .cmd  (ifb),
        .tx   (tx_b),
        .busy (busy_b)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    logic [7:0] exp_line [10];
    logic       tx_s   [LINE];
    logic       busy_s [LINE];
    logic       rdy_s  [LINE];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference line: hex id, space, 3 decimal digits x, space, 3 digits y, LF
    task automatic model_line(input int id, input int xv, input int yv);
        exp_line[0] = (id < 10) ? 8'(48 + id) : 8'(55 + id);
        exp_line[1] = 8'h20;
        exp_line[2] = 8'(48 + xv / 100);
        exp_line[3] = 8'(48 + (xv / 10) % 10);
        exp_line[4] = 8'(48 + xv % 10);
        exp_line[5] = 8'h20;
        exp_line[6] = 8'(48 + yv / 100);
        exp_line[7] = 8'(48 + (yv / 10) % 10);
        exp_line[8] = 8'(48 + yv % 10);
        exp_line[9] = 8'h0A;
    endtask

    // Wait for ready, present a command, return just after the accepting edge
    task automatic send_a(input logic [3:0] id, input logic [6:0] xv, input logic [6:0] yv,
                          input bit hold, input string tag);
        int w;
        w = 0;
        @(negedge clk);
        while (ifa.cmd_ready !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_ready_before_send"}, 64'(ifa.cmd_ready), 64'd1);
        ifa.cmd_valid = 1'b1;
        ifa.cmd_id    = id;
        ifa.x         = xv;
        ifa.y         = yv;
        model_line(int'(id), int'(xv), int'(yv));
        @(posedge clk);
        #1;
        if (!hold) ifa.cmd_valid = 1'b0;
    endtask

    // Sample one full line (cycle 0 = first cycle after acceptance) and
    // compare against exp_line. Optionally pulse a rival command mid-line.
    task automatic capture(input int inject_at, input string tag);
        int busy_cnt;
        int rdy_cnt;
        for (int j = 0; j < LINE; j++) begin
            @(negedge clk);
            tx_s[j]   = tx_a;
            busy_s[j] = busy_a;
            rdy_s[j]  = ifa.cmd_ready;
            if (inject_at >= 0 && j == inject_at) begin
                ifa.cmd_valid = 1'b1;
                ifa.cmd_id    = 4'($urandom);
                ifa.x         = 7'($urandom);
                ifa.y         = 7'($urandom);
            end
            if (inject_at >= 0 && j == inject_at + 2) ifa.cmd_valid = 1'b0;
        end
        busy_cnt = 0;
        rdy_cnt  = 0;
        for (int j = 0; j < LINE; j++) begin
            busy_cnt += int'(busy_s[j]);
            rdy_cnt  += int'(rdy_s[j]);
        end
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(LINE));
        check({tag, "_ready_low"}, 64'(rdy_cnt), 64'd0);
        for (int n = 0; n < 10; n++) begin
            logic [10*CPB-1:0] ow;
            logic [10*CPB-1:0] ew;
            logic [7:0]        dec;
            int                b;
            for (int k = 0; k < 10 * CPB; k++) begin
                b     = k / CPB;
                ow[k] = tx_s[n * 10 * CPB + k];
                ew[k] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_line[n][b-1];
            end
            for (int i = 0; i < 8; i++)
                dec[i] = tx_s[n * 10 * CPB + (i + 1) * CPB + CPB / 2];
            check($sformatf("%s_byte%0d", tag, n), 64'(dec), 64'(exp_line[n]));
            check($sformatf("%s_wave%0d", tag, n), 64'(ow), 64'(ew));
        end
    endtask

    // Cycle right after the final stop bit: back to ready, line idle
    task automatic check_idle_after(input string tag);
        @(negedge clk);
        check({tag, "_ready_after"}, 64'(ifa.cmd_ready), 64'd1);
        check({tag, "_busy_after"}, 64'(busy_a), 64'd0);
        check({tag, "_tx_after"}, 64'(tx_a), 64'd1);
    endtask

    initial begin
        logic [3:0] rid;
        logic [6:0] rx;
        logic [6:0] ry;
        int         cyc;
        int         first_hi;

        ifa.cmd_valid = 1'b0; ifa.cmd_id = 4'd0; ifa.x = 7'd0; ifa.y = 7'd0;
        ifb.cmd_valid = 1'b0; ifb.cmd_id = 4'd0; ifb.x = 7'd0; ifb.y = 7'd0;

        // Reset state
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", 64'(tx_a), 64'd1);
        check("rst_ready", 64'(ifa.cmd_ready), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_tx_b", 64'(tx_b), 64'd1);
        rst = 1'b0;
        #1;
        check("deassert_ready_low", 64'(ifa.cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        check("deassert_ready_high", 64'(ifa.cmd_ready), 64'd1);

        // "5 012 099\n"
        send_a(4'h5, 7'd12, 7'd99, 1'b0, "t1");
        capture(-1, "t1");
        check_idle_after("t1");

        // "F 127 000\n", byte 0 = 0x46 decoded LSB first
        send_a(4'hF, 7'd127, 7'd0, 1'b0, "t2");
        capture(-1, "t2");
        check_idle_after("t2");

        // Rival command mid-line is dropped
        send_a(4'($urandom), 7'($urandom), 7'($urandom), 1'b0, "ign");
        capture(150, "ign");
        check_idle_after("ign");
        repeat (20) @(negedge clk);
        check("ign_not_queued", 64'(busy_a), 64'd0);

        // cmd_valid held across two commands
        rid = 4'($urandom); rx = 7'($urandom); ry = 7'($urandom);
        send_a(4'h3, 7'd100, 7'd9, 1'b1, "b2b_a");
        ifa.cmd_id = rid; ifa.x = rx; ifa.y = ry;
        capture(-1, "b2b_a");
        check_idle_after("b2b_a");
        model_line(int'(rid), int'(rx), int'(ry));
        @(posedge clk);
        #1 ifa.cmd_valid = 1'b0;
        capture(-1, "b2b_b");
        check_idle_after("b2b_b");

        // Random commands
        for (int r = 0; r < 3; r++) begin
            send_a(4'($urandom), 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
                   1'b0, $sformatf("rnd%0d", r));
            capture(-1, $sformatf("rnd%0d", r));
            check_idle_after($sformatf("rnd%0d", r));
        end

        // Reset during data bits of byte 4 (cycles 164..195)
        send_a(4'($urandom), 7'($urandom), 7'($urandom), 1'b0, "rstmid");
        repeat (170) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid_tx", 64'(tx_a), 64'd1);
        check("rstmid_ready", 64'(ifa.cmd_ready), 64'd0);
        check("rstmid_busy", 64'(busy_a), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid_ready_low", 64'(ifa.cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        check("rstmid_ready_high", 64'(ifa.cmd_ready), 64'd1);
        send_a(4'($urandom), 7'($urandom), 7'($urandom), 1'b0, "fresh");
        capture(-1, "fresh");
        check_idle_after("fresh");

        // Full-rate bit period on the second instance
        @(negedge clk);
        check("b_ready", 64'(ifb.cmd_ready), 64'd1);
        ifb.cmd_valid = 1'b1; ifb.cmd_id = 4'h5; ifb.x = 7'd12; ifb.y = 7'd99;
        @(posedge clk);
        #1 ifb.cmd_valid = 1'b0;
        cyc      = 0;
        first_hi = -1;
        for (int j = 0; j < 30000; j++) begin
            @(negedge clk);
            if (busy_b) cyc++;
            if (first_hi < 0 && tx_b) first_hi = j;
            if (!busy_b) break;
        end
        check("b_start_bit_width", 64'(first_hi), 64'(CPB_B));
        check("b_line_cycles", 64'(cyc), 64'(100 * CPB_B));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
